// File: rtl/dual_burst_pkg.sv
// Shared types and helpers for the dual burst sequencer.
// Provides the FSM state enum, max_u() and the tick counter width helper.
package dual_burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int max_u(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Width needed to count 0..m, never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dual_burst_sequencer_window.sv
// burst_window: registered window flag, high while DELAY <= tick <= DELAY+LEN-1.
// Ports: i_clk, i_rst_n, i_tick (next tick), i_run (next run), o_win.
module burst_window #(
    parameter int DELAY = 1,
    parameter int LEN   = 1,
    parameter int W     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_tick,
    input  logic         i_run,
    output logic         o_win
);

    localparam logic [W-1:0] LO = W'(DELAY);
    localparam logic [W-1:0] HI = W'(DELAY + LEN - 1);

    logic r_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win <= 1'b0;
        end else begin
            r_win <= i_run && (i_tick >= LO) && (i_tick <= HI);
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/dual_burst_sequencer.sv
// dual_burst_sequencer: start -> one-cycle a, delayed bursts b and c, done at the
// later burst end. Ports: clk, rst_n, start, abort -> a, b, c, done, busy, overrun.
module dual_burst_sequencer
    import dual_burst_pkg::*;
#(
    parameter int B_DELAY = 1,
    parameter int B_LEN   = 3,
    parameter int C_DELAY = 2,
    parameter int C_LEN   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic a,
    output logic b,
    output logic c,
    output logic done,
    output logic busy,
    output logic overrun
);

    localparam int B_END = B_DELAY + B_LEN - 1;
    localparam int C_END = C_DELAY + C_LEN - 1;
    localparam int M_END = max_u(B_END, C_END);
    localparam int W     = cnt_w(M_END);

    localparam logic [W-1:0] M_LAST = W'(M_END);

    if (B_DELAY < 1 || B_LEN < 1 || C_DELAY < 1 || C_LEN < 1) begin : g_bad_param
        $fatal(1, "dual_burst_sequencer: DELAY and LEN parameters must be >= 1");
    end

    state_e         r_state;
    state_e         w_state_nxt;
    logic [W-1:0]   r_tick;
    logic [W-1:0]   w_tick_nxt;

    logic           w_run_nxt;
    logic           w_a_nxt;
    logic           w_done_nxt;
    logic           w_ovr_nxt;

    logic           r_a;
    logic           r_done;
    logic           r_busy;
    logic           r_overrun;
    logic           w_b;
    logic           w_c;

    // State and tick register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Next state; abort beats start in IDLE and ends a run early
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        unique case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_tick_nxt  = '0;
                end
            end
            RUN: begin
                if (abort || (r_tick == M_LAST)) begin
                    w_state_nxt = IDLE;
                    w_tick_nxt  = '0;
                end else begin
                    w_tick_nxt  = r_tick + W'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they land registered
    // in the same cycle as the tick they describe.
    always_comb begin
        w_run_nxt  = (w_state_nxt == RUN);
        w_a_nxt    = w_run_nxt && (w_tick_nxt == '0);
        w_done_nxt = w_run_nxt && (w_tick_nxt == M_LAST);
        w_ovr_nxt  = r_overrun || (start && (r_state == RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_a       <= w_a_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_run_nxt;
            r_overrun <= w_ovr_nxt;
        end
    end

    burst_window #(
        .DELAY (B_DELAY),
        .LEN   (B_LEN),
        .W     (W)
    ) u_win_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (w_tick_nxt),
        .i_run   (w_run_nxt),
        .o_win   (w_b)
    );

    burst_window #(
        .DELAY (C_DELAY),
        .LEN   (C_LEN),
        .W     (W)
    ) u_win_c (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (w_tick_nxt),
        .i_run   (w_run_nxt),
        .o_win   (w_c)
    );

    assign a       = r_a;
    assign b       = w_b;
    assign c       = w_c;
    assign done    = r_done;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
